// File: rtl/iomem_timer_pkg.sv
// Shared constants, FSM encoding and helpers for the iomem timer block.
package iomem_timer_pkg;

    localparam logic [3:0] OFF_CTRL   = 4'h0;
    localparam logic [3:0] OFF_LOAD   = 4'h4;
    localparam logic [3:0] OFF_COUNT  = 4'h8;
    localparam logic [3:0] OFF_STATUS = 4'hC;
    localparam logic [7:0] STRIDE     = 8'h10;

    localparam int unsigned CTRL_EN      = 0;
    localparam int unsigned CTRL_RELOAD  = 1;
    localparam int unsigned CTRL_IE      = 2;
    localparam int unsigned CTRL_PRE_LSB = 8;
    localparam int unsigned CTRL_PRE_MSB = 23;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_e;

    function automatic logic [31:0] strb_merge(input logic [31:0] old,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  wstrb);
        logic [31:0] mask;
        mask = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
        return (old & ~mask) | (wdata & mask);
    endfunction

    function automatic logic [31:0] ctrl_pack(input logic en, input logic reload,
                                              input logic ie, input logic [15:0] pre);
        logic [31:0] w;
        w = '0;
        w[CTRL_EN]                   = en;
        w[CTRL_RELOAD]               = reload;
        w[CTRL_IE]                   = ie;
        w[CTRL_PRE_MSB:CTRL_PRE_LSB] = pre;
        return w;
    endfunction

endpackage

// File: rtl/iomem_timer_if.sv
// iomem bus bundle between the SoC initiator and the timer responder.
interface iomem_timer_if;
    logic        valid;
    logic        ready;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output valid, wstrb, addr, wdata, input  ready, rdata);
    modport slave  (input  valid, wstrb, addr, wdata, output ready, rdata);
endinterface

// File: rtl/iomem_timer_chan.sv
// One timer channel: prescaler, down counter with reload, sticky EXPIRED and registered irq.
module iomem_timer_chan
    import iomem_timer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        ctrl_we,
    input  logic        load_we,
    input  logic        status_we,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    output logic [31:0] ctrl_rd,
    output logic [31:0] load_rd,
    output logic [31:0] count_rd,
    output logic        expired,
    output logic        irq
);

    logic        en_q, en_d, reload_q, reload_d, ie_q, ie_d;
    logic [15:0] pre_q, pre_d, presc_q, presc_d;
    logic [31:0] load_q, load_d, count_q, count_d;
    logic        expired_q, expired_d, irq_q, irq_d;
    logic        tick;

    always_comb begin
        en_d      = en_q;
        reload_d  = reload_q;
        ie_d      = ie_q;
        pre_d     = pre_q;
        presc_d   = presc_q;
        load_d    = load_q;
        count_d   = count_q;
        expired_d = expired_q;
        // >= keeps the prescaler from running away if PRE is lowered mid-period
        tick      = en_q && (presc_q >= pre_q);

        if (en_q) presc_d = tick ? '0 : presc_q + 16'd1;

        // Clear before set so an expiry in the same cycle wins.
        if (status_we && wstrb[0] && wdata[0]) expired_d = 1'b0;

        if (tick) begin
            if (count_q != '0) begin
                count_d = count_q - 32'd1;
            end else begin
                expired_d = 1'b1;
                if (reload_q) count_d = load_q;
                else          en_d    = 1'b0;
            end
        end

        if (ctrl_we) begin
            if (wstrb[0]) begin
                en_d     = wdata[CTRL_EN];
                reload_d = wdata[CTRL_RELOAD];
                ie_d     = wdata[CTRL_IE];
                if (!en_q && wdata[CTRL_EN]) begin
                    count_d = load_q;
                    presc_d = '0;
                end
            end
            if (wstrb[1]) pre_d[7:0]  = wdata[15:8];
            if (wstrb[2]) pre_d[15:8] = wdata[23:16];
        end

        if (load_we) load_d = strb_merge(load_q, wdata, wstrb);

        irq_d = expired_q & ie_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_q      <= 1'b0;
            reload_q  <= 1'b0;
            ie_q      <= 1'b0;
            pre_q     <= '0;
            presc_q   <= '0;
            load_q    <= '0;
            count_q   <= '0;
            expired_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            en_q      <= en_d;
            reload_q  <= reload_d;
            ie_q      <= ie_d;
            pre_q     <= pre_d;
            presc_q   <= presc_d;
            load_q    <= load_d;
            count_q   <= count_d;
            expired_q <= expired_d;
            irq_q     <= irq_d;
        end
    end

    assign ctrl_rd  = ctrl_pack(en_q, reload_q, ie_q, pre_q);
    assign load_rd  = load_q;
    assign count_rd = count_q;
    assign expired  = expired_q;
    assign irq      = irq_q;

endmodule

// File: rtl/iomem_timer.sv
// iomem responder: window decode, one-cycle ACK handshake, read mux and NTIMERS timer channels.
module iomem_timer
    import iomem_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0300_0000,
    parameter int unsigned NTIMERS   = 2
) (
    input  logic               clk,
    input  logic               reset,
    iomem_timer_if.slave       iomem,
    output logic [NTIMERS-1:0] irq
);

    state_e      state_q, state_d;
    logic [31:0] rdata_q, rdata_d;
    logic        hit, accept, is_write;
    logic [3:0]  sel_idx, sel_off;
    logic [NTIMERS:0][31:0] rd_chain;

    assign hit      = (iomem.addr[31:8] == BASE_ADDR[31:8]);
    assign accept   = (state_q == IDLE) && iomem.valid && hit;
    assign is_write = |iomem.wstrb;
    assign sel_idx  = 4'(iomem.addr[7:0] / STRIDE);
    assign sel_off  = 4'(iomem.addr[7:0] % STRIDE);
    assign rd_chain[0] = '0;

    for (genvar g = 0; g < NTIMERS; g++) begin : g_chan
        logic        sel, expired;
        logic [31:0] ctrl_rd, load_rd, count_rd, chan_word;

        assign sel = accept && is_write && (sel_idx == 4'(g));

        iomem_timer_chan u_chan (
            .clk       (clk),
            .reset     (reset),
            .ctrl_we   (sel && (sel_off == OFF_CTRL)),
            .load_we   (sel && (sel_off == OFF_LOAD)),
            .status_we (sel && (sel_off == OFF_STATUS)),
            .wstrb     (iomem.wstrb),
            .wdata     (iomem.wdata),
            .ctrl_rd   (ctrl_rd),
            .load_rd   (load_rd),
            .count_rd  (count_rd),
            .expired   (expired),
            .irq       (irq[g])
        );

        always_comb begin
            chan_word = '0;
            if (sel_idx == 4'(g)) begin
                case (sel_off)
                    OFF_CTRL:   chan_word = ctrl_rd;
                    OFF_LOAD:   chan_word = load_rd;
                    OFF_COUNT:  chan_word = count_rd;
                    OFF_STATUS: chan_word = {31'b0, expired};
                    default:    chan_word = '0;
                endcase
            end
        end

        // Unselected channels contribute zero, so the OR chain acts as the read mux.
        assign rd_chain[g+1] = rd_chain[g] | chan_word;
    end

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = ACK;
                    rdata_d = is_write ? '0 : rd_chain[NTIMERS];
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
        end
    end

    assign iomem.ready = (state_q == ACK);
    assign iomem.rdata = rdata_q;

endmodule
